mem_subsys: RTL and testbench

MEM_SUBSYS -- requirements
Module: mem_subsys

---
 rtl/mem_subsys_pkg.sv | 15 +
 rtl/mem_subsys_sp_ram.sv | 27 ++
 rtl/mem_subsys.sv | 155 +++++++++++++++
 tb/tb_mem_subsys.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_subsys_pkg.sv
// Shared types and constants for the memory subsystem: sweep FSM states and
// the register offsets of the MMIO window that sits just above RAM.
package mem_subsys_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [1:0] MMIO_SW     = 2'd0;
    localparam logic [1:0] MMIO_LED    = 2'd1;
    localparam logic [1:0] MMIO_TCOUNT = 2'd2;
    localparam logic [1:0] MMIO_TCMP   = 2'd3;

endpackage

// File: rtl/mem_subsys_sp_ram.sv
// Single-port RAM with registered read; a read that coincides with a write
// to the same word returns the word's previous contents.
module sp_ram #(
    parameter  int DATA_WIDTH = 16,
    parameter  int RAM_DEPTH  = 1024,
    localparam int AW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_subsys.sv
// Data-memory subsystem: zero-fills the RAM after reset, then serves CPU
// accesses to RAM and to a four-register MMIO window (switches, LEDs, timer).
module mem_subsys
    import mem_subsys_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int RAM_DEPTH  = 1024
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] sw_in,
    output logic [DATA_WIDTH-1:0] led_out,
    output logic                  timer_irq
);

    localparam int                    RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] RAM_BASE = ADDR_WIDTH'(RAM_DEPTH);
    localparam logic [RAM_AW-1:0]     CLR_LAST = RAM_AW'(RAM_DEPTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [RAM_AW-1:0]     r_clr_addr;
    logic [RAM_AW-1:0]     w_clr_addr_next;

    logic                  w_ram_we;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    logic                  w_run;
    logic                  w_is_ram;
    logic                  w_is_mmio;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [1:0]            w_mmio_sel;
    logic                  w_wr_led;
    logic                  w_wr_tcmp;
    logic [DATA_WIDTH-1:0] w_mmio_rdata;

    logic [DATA_WIDTH-1:0] r_led;
    logic [DATA_WIDTH-1:0] r_tcmp;
    logic [DATA_WIDTH-1:0] r_tcount;
    logic                  r_irq;
    logic                  r_rd_ram;
    logic [DATA_WIDTH-1:0] r_mmio_rdata;

    assign w_run      = (r_state == RUN);
    assign w_is_ram   = (cpu_addr < RAM_BASE);
    assign w_offset   = cpu_addr - RAM_BASE;
    assign w_is_mmio  = !w_is_ram && (w_offset < ADDR_WIDTH'(4));
    assign w_mmio_sel = w_offset[1:0];
    assign w_wr_led   = w_run && cpu_we && w_is_mmio && (w_mmio_sel == MMIO_LED);
    assign w_wr_tcmp  = w_run && cpu_we && w_is_mmio && (w_mmio_sel == MMIO_TCMP);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // The sweep owns the RAM port in CLEAR; Reset gates every write so a held
    // reset never disturbs memory contents.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_ram_we        = 1'b0;
        w_ram_addr      = cpu_addr[RAM_AW-1:0];
        w_ram_wdata     = cpu_wdata;
        case (r_state)
            CLEAR: begin
                w_ram_we        = !Reset;
                w_ram_addr      = r_clr_addr;
                w_ram_wdata     = '0;
                w_clr_addr_next = r_clr_addr + RAM_AW'(1);
                if (r_clr_addr == CLR_LAST) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_ram_we = !Reset && cpu_we && w_is_ram;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_ram (
        .i_clk   (Clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // MMIO read data is captured in the access cycle so it matches the RAM's
    // one-cycle latency and naturally returns pre-write register values.
    always_comb begin
        w_mmio_rdata = '0;
        if (w_run && w_is_mmio) begin
            case (w_mmio_sel)
                MMIO_SW:     w_mmio_rdata = sw_in;
                MMIO_LED:    w_mmio_rdata = r_led;
                MMIO_TCOUNT: w_mmio_rdata = r_tcount;
                MMIO_TCMP:   w_mmio_rdata = r_tcmp;
                default:     w_mmio_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_led        <= '0;
            r_tcmp       <= '1;
            r_tcount     <= '0;
            r_irq        <= 1'b0;
            r_rd_ram     <= 1'b0;
            r_mmio_rdata <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= cpu_wdata;
            end
            if (w_wr_tcmp) begin
                r_tcmp <= cpu_wdata;
            end
            r_tcount <= w_run ? (r_tcount + DATA_WIDTH'(1)) : '0;
            // A compare-register write takes priority over a simultaneous match.
            if (w_wr_tcmp) begin
                r_irq <= 1'b0;
            end else if (w_run && (r_tcount == r_tcmp)) begin
                r_irq <= 1'b1;
            end
            r_rd_ram     <= w_run && w_is_ram;
            r_mmio_rdata <= w_mmio_rdata;
        end
    end

    assign cpu_rdata = r_rd_ram ? w_ram_rdata : r_mmio_rdata;
    assign ready     = w_run;
    assign led_out   = r_led;
    assign timer_irq = r_irq;

endmodule

// File: tb/tb_mem_subsys.sv
// Directed bench for mem_subsys: clear sweep, RAM/MMIO access, timer flag,
// reset behaviour, and a narrow parameterisation for counter wrap.
module tb_mem_subsys;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic        ready;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        timer_irq;

    logic        Reset2;
    logic [5:0]  cpu_addr2;
    logic [7:0]  cpu_wdata2;
    logic        cpu_we2;
    logic [7:0]  cpu_rdata2;
    logic        ready2;
    logic [7:0]  sw_in2;
    logic [7:0]  led_out2;
    logic        timer_irq2;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 Clk = ~Clk;

    mem_subsys #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .RAM_DEPTH(1024)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .ready     (ready),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    mem_subsys #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RAM_DEPTH(32)) dut_small (
        .Clk       (Clk),
        .Reset     (Reset2),
        .cpu_addr  (cpu_addr2),
        .cpu_wdata (cpu_wdata2),
        .cpu_we    (cpu_we2),
        .cpu_rdata (cpu_rdata2),
        .ready     (ready2),
        .sw_in     (sw_in2),
        .led_out   (led_out2),
        .timer_irq (timer_irq2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    task automatic wr(input logic [10:0] a, input logic [15:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic rd(input logic [10:0] a);
        cpu_addr = a;
        cpu_we   = 1'b0;
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; sw_in = '0;
        Reset2 = 1'b1; cpu_addr2 = '0; cpu_wdata2 = '0; cpu_we2 = 1'b0; sw_in2 = '0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_irq", 32'(timer_irq), 32'd0);
        Reset = 1'b0;
        wait_ready(cnt);
        check("sweep_len", 32'(cnt), 32'd1024);

        // Timer: TCOUNT is 0 on the first RUN cycle.
        wr(11'd1027, 16'd20);
        check("irq_after_tcmp_wr", 32'(timer_irq), 32'd0);
        cnt = 0;
        while (timer_irq !== 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("irq_rise_delay", 32'(cnt), 32'd20);
        repeat (3) tick();
        check("irq_sticky", 32'(timer_irq), 32'd1);
        wr(11'd1027, 16'd1000);
        check("irq_clr_by_wr", 32'(timer_irq), 32'd0);
        rd(11'd1026);
        check("tcount_read", 32'(cpu_rdata), 32'd25);
        wr(11'd1027, 16'd30);
        repeat (3) tick();
        check("irq_before_match", 32'(timer_irq), 32'd0);
        wr(11'd1027, 16'd1000);
        check("irq_clear_wins", 32'(timer_irq), 32'd0);
        tick();
        check("irq_clear_wins_hold", 32'(timer_irq), 32'd0);
        cpu_addr = 11'd1027; cpu_wdata = 16'd2000; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        check("tcmp_rdw_old", 32'(cpu_rdata), 32'd1000);
        tick();
        check("tcmp_readback", 32'(cpu_rdata), 32'd2000);

        // RAM access and read-during-write.
        cpu_addr = 11'd5; cpu_wdata = 16'hBEEF; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        check("ram_rdw_old", 32'(cpu_rdata), 32'h0000);
        tick();
        check("ram_rd5", 32'(cpu_rdata), 32'hBEEF);
        wr(11'd1023, 16'h1111);
        rd(11'd1023);
        check("ram_rd1023", 32'(cpu_rdata), 32'h1111);
        rd(11'd5);
        check("ram_rd5_again", 32'(cpu_rdata), 32'hBEEF);

        // MMIO.
        wr(11'd1025, 16'h00A5);
        check("led_out", 32'(led_out), 32'h00A5);
        rd(11'd1025);
        check("led_read", 32'(cpu_rdata), 32'h00A5);
        cpu_addr = 11'd1025; cpu_wdata = 16'h003C; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        check("led_rdw_old", 32'(cpu_rdata), 32'h00A5);
        check("led_out_new", 32'(led_out), 32'h003C);
        sw_in = 16'h1234;
        cpu_addr = 11'd1024;
        tick();
        sw_in = 16'h4321;
        check("sw_read", 32'(cpu_rdata), 32'h1234);
        rd(11'd1030);
        check("unmapped_read", 32'(cpu_rdata), 32'h0);
        wr(11'd1028, 16'h7777);
        rd(11'd4);
        check("unmapped_no_alias", 32'(cpu_rdata), 32'h0);
        rd(11'd1028);
        check("unmapped_read2", 32'(cpu_rdata), 32'h0);

        // Preload, then reset must zero memory.
        wr(11'd0, 16'hAAAA);
        wr(11'd512, 16'h5555);
        rd(11'd512);
        check("preload512", 32'(cpu_rdata), 32'h5555);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst2_rdata", 32'(cpu_rdata), 32'h0);
        check("rst2_led", 32'(led_out), 32'h0);
        wait_ready(cnt);
        check("sweep_len2", 32'(cnt), 32'd1024);
        rd(11'd0);
        check("clr_rd0", 32'(cpu_rdata), 32'h0);
        rd(11'd512);
        check("clr_rd512", 32'(cpu_rdata), 32'h0);
        rd(11'd1023);
        check("clr_rd1023", 32'(cpu_rdata), 32'h0);

        // Reset mid-sweep, with LED writes attempted during CLEAR.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        repeat (300) tick();
        check("mid_sweep_ready", 32'(ready), 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        cpu_addr = 11'd1025; cpu_wdata = 16'h005A; cpu_we = 1'b1;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 2000) begin
            if (cnt == 10) cpu_we = 1'b0;
            cnt++;
            tick();
        end
        cpu_we = 1'b0;
        check("sweep_len_restart", 32'(cnt), 32'd1024);
        check("led_ignored_clear", 32'(led_out), 32'h0);

        // Narrow instance: 32-cycle clear and 8-bit counter wrap.
        Reset2 = 1'b0;
        cnt = 0;
        while (ready2 !== 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        check("small_sweep_len", 32'(cnt), 32'd32);
        cpu_addr2 = 6'd34;
        repeat (256) tick();
        check("small_tcount_ff", 32'(cpu_rdata2), 32'hFF);
        tick();
        check("small_tcount_wrap", 32'(cpu_rdata2), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
